// File: rtl/latch_pkg.sv
// latch_pkg -- shared types and constants for the latch_playback block.
//   byte_t        : one 8-bit switch byte
//   state_t       : display mode, LIVE (led follows D) or PLAY (led shows hold_reg)
//   DEPTH_DEFAULT : default number of bytes held by the playback buffer
package latch_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        LIVE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int DEPTH_DEFAULT = 4;

endpackage : latch_pkg

// File: rtl/rise_detect.sv
// rise_detect -- registered rising-edge detector for one level input.
//   clk     : system clock
//   rst_n   : synchronous active-low reset (clears the delayed copy)
//   i_level : level input (button)
//   o_rise  : high for the single cycle in which i_level is high and was low
//             at the previous clock edge
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    // A held button only produces one pulse: the delayed copy catches up after
    // one cycle and masks the level from then on.
    assign o_rise = i_level & ~r_level_q;

endmodule : rise_detect

// File: rtl/latch_playback.sv
// latch_playback -- captures switch bytes into a small circular buffer and plays
// them back one at a time on the LEDs.
//   clk       : system clock, all state changes on its rising edge
//   rst_n     : synchronous active-low reset
//   D         : switch byte to capture
//   capture   : button, rising edge pushes D into the buffer
//   step      : button, rising edge (PLAY only) pops the next byte onto the LEDs
//   sel       : 1 = LIVE, 0 = PLAY
//   led       : D in LIVE, last popped byte in PLAY
//   count     : number of bytes stored
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, set when a capture was dropped
//   underrun  : one-cycle pulse when a step found the buffer empty
//   sel_alert : !sel
module latch_playback
    import latch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               D,
    input  logic                     capture,
    input  logic                     step,
    input  logic                     sel,
    output logic [7:0]               led,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underrun,
    output logic                     sel_alert
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    byte_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    byte_t            r_hold;
    logic             r_overflow;
    logic             r_underrun;
    state_t           r_state;
    state_t           w_state_next;

    logic w_cap_rise;
    logic w_step_rise;
    logic w_full;
    logic w_empty;
    logic w_pop_req;
    logic w_pop_ok;
    logic w_push_ok;

    rise_detect u_cap_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (capture),
        .o_rise  (w_cap_rise)
    );

    rise_detect u_step_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (step),
        .o_rise  (w_step_rise)
    );

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LIVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LIVE:    if (!sel) w_state_next = PLAY;
            PLAY:    if (sel)  w_state_next = LIVE;
            default: w_state_next = LIVE;
        endcase
    end

    // ---------------- push / pop arbitration ----------------
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_req = w_step_rise && (r_state == PLAY);
    assign w_pop_ok  = w_pop_req && !w_empty;
    // A full buffer still accepts a push when a pop frees the head slot in the
    // same cycle; the head is read before the tail slot is overwritten.
    assign w_push_ok = w_cap_rise && (!w_full || w_pop_ok);

    // NOTE: the byte storage has no reset; count and pointers define which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= D;
        end
    end

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so they wrap
    // from DEPTH-1 to 0 by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hold     <= 8'h00;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_hold   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_cap_rise && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            r_underrun <= w_pop_req && w_empty;
        end
    end

    // ---------------- outputs ----------------
    assign led       = (r_state == LIVE) ? D : r_hold;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underrun  = r_underrun;
    assign sel_alert = ~sel;

endmodule : latch_playback

// File: tb/tb_latch_playback.sv
// tb_latch_playback -- directed self-checking bench for latch_playback (DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_latch_playback;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       capture;
    logic       step;
    logic       sel;
    logic [7:0] led;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underrun;
    logic       sel_alert;

    int n_checks = 0;
    int n_fail   = 0;

    latch_playback #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D         (d),
        .capture   (capture),
        .step      (step),
        .sel       (sel),
        .led       (led),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underrun  (underrun),
        .sel_alert (sel_alert)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Press and release capture; the push happens at the first edge.
    task automatic press_capture(input logic [7:0] val);
        d       = val;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tick();
    endtask

    // Press step, check the byte shown right after the sampling edge, release.
    task automatic press_step(input string tag, input logic [7:0] exp_led);
        step = 1'b1;
        tick();
        check(tag, led, exp_led);
        step = 1'b0;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        d       = 8'h11;
        capture = 1'b0;
        step    = 1'b0;
        sel     = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // ---- reset state ----
        check("rst_count",     count,     3'd0);
        check("rst_empty",     empty,     1'b1);
        check("rst_full",      full,      1'b0);
        check("rst_overflow",  overflow,  1'b0);
        check("rst_underrun",  underrun,  1'b0);
        check("rst_led_live",  led,       8'h11);
        check("rst_sel_alert", sel_alert, 1'b0);

        // ---- basic capture and playback ----
        press_capture(8'hA5);
        check("live_led_a5", led, 8'hA5);
        press_capture(8'h3C);
        press_capture(8'hFF);
        check("cap3_count", count, 3'd3);
        d = 8'h5A;
        #1;
        check("live_led_follow", led, 8'h5A);
        sel = 1'b0;
        #1;
        check("sel_alert_play", sel_alert, 1'b1);
        tick();
        check("play_hold_init", led, 8'h00);
        press_step("play_a5", 8'hA5);
        press_step("play_3c", 8'h3C);
        press_step("play_ff", 8'hFF);
        check("play_count0", count, 3'd0);
        check("play_empty",  empty, 1'b1);

        // ---- underrun after reset ----
        do_reset();
        sel = 1'b0;
        tick();
        step = 1'b1;
        tick();
        check("underrun_pulse", underrun, 1'b1);
        check("underrun_led",   led,      8'h00);
        tick();
        check("underrun_one_cycle", underrun, 1'b0);
        step = 1'b0;
        tick();

        // ---- overflow ----
        do_reset();
        sel = 1'b1;
        press_capture(8'h11);
        press_capture(8'h22);
        press_capture(8'h33);
        check("ovf_not_full3", full, 1'b0);
        press_capture(8'h44);
        check("ovf_full4",   full,     1'b1);
        check("ovf_clear4",  overflow, 1'b0);
        press_capture(8'h55);
        check("ovf_set",     overflow, 1'b1);
        check("ovf_count",   count,    3'd4);
        sel = 1'b0;
        tick();
        press_step("ovf_p11", 8'h11);
        press_step("ovf_p22", 8'h22);
        press_step("ovf_p33", 8'h33);
        press_step("ovf_p44", 8'h44);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_empty",  empty,    1'b1);

        // ---- simultaneous push and pop ----
        do_reset();
        sel = 1'b1;
        press_capture(8'h01);
        press_capture(8'h02);
        sel = 1'b0;
        tick();
        d = 8'h03; capture = 1'b1; step = 1'b1;
        tick();
        check("simul2_count", count, 3'd2);
        check("simul2_led",   led,   8'h01);
        capture = 1'b0; step = 1'b0;
        tick();
        press_capture(8'h04);
        press_capture(8'h05);
        check("simul4_pre_full", full, 1'b1);
        d = 8'h06; capture = 1'b1; step = 1'b1;
        tick();
        check("simul4_count",    count,    3'd4);
        check("simul4_overflow", overflow, 1'b0);
        check("simul4_led",      led,      8'h02);
        capture = 1'b0; step = 1'b0;
        tick();
        press_step("simul_p03", 8'h03);
        press_step("simul_p04", 8'h04);
        press_step("simul_p05", 8'h05);
        press_step("simul_p06", 8'h06);

        // ---- held step and pointer wrap ----
        do_reset();
        sel = 1'b1;
        press_capture(8'hAA);
        press_capture(8'hBB);
        sel = 1'b0;
        tick();
        step = 1'b1;
        repeat (20) tick();
        check("held_count", count, 3'd1);
        check("held_led",   led,   8'hAA);
        step = 1'b0;
        tick();
        press_capture(8'hC1);
        press_capture(8'hC2);
        press_capture(8'hC3);
        check("wrap_full", full, 1'b1);
        press_step("wrap_pbb", 8'hBB);
        press_step("wrap_pc1", 8'hC1);
        press_capture(8'hC4);
        press_capture(8'hC5);
        check("wrap_count4", count, 3'd4);
        press_step("wrap_pc2", 8'hC2);
        press_step("wrap_pc3", 8'hC3);
        press_step("wrap_pc4", 8'hC4);
        press_step("wrap_pc5", 8'hC5);

        // ---- reset mid-operation in PLAY ----
        do_reset();
        sel = 1'b1;
        press_capture(8'h10);
        press_capture(8'h20);
        press_capture(8'h30);
        press_capture(8'h40);
        press_capture(8'h50);
        sel = 1'b0;
        tick();
        press_step("mid_p10", 8'h10);
        check("mid_pre_count", count, 3'd3);
        d = 8'h77;
        do_reset();
        check("mid_count",    count,    3'd0);
        check("mid_empty",    empty,    1'b1);
        check("mid_full",     full,     1'b0);
        check("mid_overflow", overflow, 1'b0);
        check("mid_led_live", led,      8'h77);
        tick();
        check("mid_play_led", led,      8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_latch_playback

// File: doc/latch_playback.md
LATCH_PLAYBACK -- requirements
Module: latch_playback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of stored bytes (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port D  input  8  switch byte to capture.
REQ-005 SHALL have port capture  input  1  level button; a rising edge requests a write of D.
REQ-006 SHALL have port step  input  1  level button; a rising edge requests a read of the next stored byte.
REQ-007 SHALL have port sel  input  1  mode: 1 = LIVE, 0 = PLAY.
REQ-008 SHALL have port led  output  8  displayed byte.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  number of stored bytes.
REQ-010 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.
REQ-011 SHALL have port overflow  output  1  sticky: a capture was dropped.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse: a step found the buffer empty.
REQ-013 SHALL have port sel_alert  output  1  equals !sel, combinational.

Function
REQ-014 SHALL detect edges as cap_rise = capture & ~capture_q and step_rise = step & ~step_q, where capture_q and step_q are the inputs registered one cycle earlier.
REQ-015 SHALL implement a circular byte buffer with write pointer, read pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL, on cap_rise when not full, store D at the write pointer and advance it; on cap_rise when full with no pop in the same cycle, drop D and set overflow.
REQ-017 SHALL act on step_rise only in state PLAY; in LIVE, step_rise is ignored with no pop and no underrun.
REQ-018 SHALL, on step_rise in PLAY when not empty, load the head byte into hold_reg and advance the read pointer; led shows the new byte from the clock edge at which step_rise is sampled (1-cycle latency from the first high sample of step).
REQ-019 SHALL, on step_rise in PLAY when empty, leave hold_reg unchanged and assert underrun for exactly one cycle.
REQ-020 SHALL handle a simultaneous push and pop as follows: 0<count<DEPTH, both occur and count is unchanged; count==DEPTH, both occur with no overflow; count==0, the push occurs, the pop fails and underrun pulses.
REQ-021 SHALL implement FSM states LIVE and PLAY: LIVE->PLAY when sel==0; PLAY->LIVE when sel==1; the transition takes effect on the next clock edge.
REQ-022 SHALL drive led = D in LIVE and led = hold_reg in PLAY.
REQ-023 SHALL, on entering PLAY, keep the last hold_reg value and SHALL NOT pop automatically.
REQ-024 SHALL ignore held buttons: one press yields exactly one push or pop regardless of its duration.

Reset
REQ-025 SHALL, on a clk edge with rst_n==0, clear pointers, count, hold_reg (8'h00), overflow, underrun, capture_q and step_q, and force state LIVE.
REQ-026 SHALL discard buffer contents on reset mid-operation; after reset, count=0, empty=1, full=0, and led=D (LIVE).
REQ-027 SHALL not require the buffer storage array itself to be reset.

Structure
REQ-028 SHALL take the byte typedef (byte_t, 8 bits), the state enum (LIVE, PLAY) and DEPTH_DEFAULT=4 from shared package latch_pkg.
REQ-029 SHALL instantiate sub-module rise_detect (1-bit registered rising-edge detector with synchronous active-low reset) twice, once for capture and once for step.

Verification
REQ-030 SHALL cover: reset, then capture D=8'hA5, 8'h3C, 8'hFF in LIVE -> count=3; led follows D live; then sel=0 and three steps -> led shows A5, 3C, FF in order; count returns to 0 and empty=1.
REQ-031 SHALL cover: 5 captures with DEPTH=4 -> full=1 after the 4th; the 5th is dropped and overflow=1 and stays 1; playback returns only the first 4 bytes.
REQ-032 SHALL cover: step in PLAY with count=0 -> underrun high for exactly 1 cycle; led unchanged (8'h00 after reset).
REQ-033 SHALL cover: capture and step rising in the same cycle at count=2 -> count stays 2; led shows the old head; the new byte is stored at the tail. The same stimulus at count=4 -> no overflow, count=4.
REQ-034 SHALL cover: step held high for 20 cycles -> exactly one pop; 6 captures with write-pointer wrap -> bytes read back in FIFO order.
REQ-035 SHALL cover: rst_n=0 for one cycle with count=3 in PLAY -> next cycle count=0, state LIVE, led=D, overflow=0.
